// File: rtl/core_irq_arbiter.sv
// core_irq_arbiter: captures rising edges on 64 interrupt lines into pending
// latches and presents one winner at a time to the core interrupt manager.
// The winner is chosen by ICT level (3 highest), with ties going to the lowest
// number. A programmable gap of idle cycles follows every acknowledge.
//
// Handshake: oEXT_ACTIVE/oEXT_NUM are held stable from the first cycle of
// PRESENT until iEXT_ACK is sampled high. The request drops on the edge that
// samples the ACK. An ACK seen in any other state has no effect.
module core_irq_arbiter #(
   parameter int P_GAP = 2
) (
   input  logic        iCLOCK,
   input  logic        iRESET_SYNC,
   input  logic [63:0] iIRQ_REQ,
   input  logic        iICT_VALID,
   input  logic [5:0]  iICT_ENTRY,
   input  logic        iICT_CONF_MASK,
   input  logic        iICT_CONF_VALID,
   input  logic [1:0]  iICT_CONF_LEVEL,
   output logic        oEXT_ACTIVE,
   output logic [5:0]  oEXT_NUM,
   input  logic        iEXT_ACK,
   output logic [63:0] oPENDING,
   output logic        oBUSY
);

   localparam int GW = (P_GAP < 1) ? 1 : $clog2(P_GAP + 1);

   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_PRESENT, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [5:0]    b_num_q, b_num_d;
   logic [63:0]   pending_q, pending_d;
   logic [63:0]   req_hist_q, req_hist_d;
   logic [63:0]   mask_q, mask_d;
   logic [63:0]   valid_q, valid_d;
   logic [1:0]    level_q [64];
   logic [1:0]    level_d [64];
   logic [GW-1:0] gap_q, gap_d;
   logic          ext_active_q, ext_active_d;
   logic [5:0]    ext_num_q, ext_num_d;

   logic [63:0]   eligible;
   logic          any_elig;
   logic [5:0]    win_num;
   logic [1:0]    win_lvl;
   logic [1:0]    lvl;

   // Find the eligible source with the highest effective level, lowest number on ties
   always_comb begin
      eligible = pending_q & (~valid_q | mask_q);
      any_elig = 1'b0;
      win_num  = 6'd0;
      win_lvl  = 2'd0;
      lvl      = 2'd0;
      for (int n = 0; n < 64; n++) begin
         lvl = valid_q[n] ? level_q[n] : 2'd0;
         if (eligible[n] && (!any_elig || (lvl > win_lvl))) begin
            any_elig = 1'b1;
            win_num  = 6'(n);
            win_lvl  = lvl;
         end
      end
   end

   // Next-state logic: FSM, pending latches, ICT shadow and registered outputs
   always_comb begin
      state_d      = state_q;
      b_num_d      = b_num_q;
      pending_d    = pending_q;
      req_hist_d   = iIRQ_REQ;
      mask_d       = mask_q;
      valid_d      = valid_q;
      level_d      = level_q;
      gap_d        = gap_q;
      ext_active_d = ext_active_q;
      ext_num_d    = ext_num_q;

      if (iICT_VALID) begin
         mask_d[iICT_ENTRY]  = iICT_CONF_MASK;
         valid_d[iICT_ENTRY] = iICT_CONF_VALID;
         level_d[iICT_ENTRY] = iICT_CONF_LEVEL;
      end

      unique case (state_q)
         S_IDLE: begin
            if (any_elig) begin
               b_num_d = win_num;
               state_d = S_SELECT;
            end
         end
         S_SELECT: begin
            ext_active_d = 1'b1;
            ext_num_d    = b_num_q;
            state_d      = S_PRESENT;
         end
         S_PRESENT: begin
            if (iEXT_ACK) begin
               pending_d[b_num_q] = 1'b0;
               ext_active_d       = 1'b0;
               gap_d              = GW'(P_GAP);
               state_d            = (P_GAP > 0) ? S_GAP : S_IDLE;
            end
         end
         S_GAP: begin
            gap_d = gap_q - GW'(1);
            if (gap_q <= GW'(1)) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A fresh rising edge beats a same-cycle acknowledge of that bit
      pending_d = pending_d | (iIRQ_REQ & ~req_hist_q);
   end

   // State register. The request history keeps tracking the lines during reset,
   // so a line held high across reset is not seen as a new edge afterwards.
   always_ff @(posedge iCLOCK) begin
      req_hist_q <= req_hist_d;
      if (iRESET_SYNC) begin
         state_q      <= S_IDLE;
         b_num_q      <= 6'd0;
         pending_q    <= 64'd0;
         mask_q       <= 64'd0;
         valid_q      <= 64'd0;
         gap_q        <= '0;
         ext_active_q <= 1'b0;
         ext_num_q    <= 6'd0;
         for (int n = 0; n < 64; n++) begin
            level_q[n] <= 2'd0;
         end
      end else begin
         state_q      <= state_d;
         b_num_q      <= b_num_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         valid_q      <= valid_d;
         level_q      <= level_d;
         gap_q        <= gap_d;
         ext_active_q <= ext_active_d;
         ext_num_q    <= ext_num_d;
      end
   end

   assign oEXT_ACTIVE = ext_active_q;
   assign oEXT_NUM    = ext_num_q;
   assign oPENDING    = pending_q;
   assign oBUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_core_irq_arbiter.sv
// Directed bench for core_irq_arbiter with hand-computed expectations (P_GAP=2).
module tb_core_irq_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] req;
   logic        ict_valid;
   logic [5:0]  ict_entry;
   logic        ict_mask;
   logic        ict_cvalid;
   logic [1:0]  ict_level;
   logic        ext_active;
   logic [5:0]  ext_num;
   logic        ext_ack;
   logic [63:0] pending;
   logic        busy;

   int total = 0;
   int bad   = 0;

   core_irq_arbiter #(.P_GAP(2)) dut (
      .iCLOCK          (clk),
      .iRESET_SYNC     (rst),
      .iIRQ_REQ        (req),
      .iICT_VALID      (ict_valid),
      .iICT_ENTRY      (ict_entry),
      .iICT_CONF_MASK  (ict_mask),
      .iICT_CONF_VALID (ict_cvalid),
      .iICT_CONF_LEVEL (ict_level),
      .oEXT_ACTIVE     (ext_active),
      .oEXT_NUM        (ext_num),
      .iEXT_ACK        (ext_ack),
      .oPENDING        (pending),
      .oBUSY           (busy)
   );

   // Clock
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic ict_wr(input logic [5:0] e, input logic m, input logic v, input logic [1:0] l);
      ict_valid  = 1'b1;
      ict_entry  = e;
      ict_mask   = m;
      ict_cvalid = v;
      ict_level  = l;
      step(1);
      ict_valid  = 1'b0;
   endtask

   // ACK the current request, check the two gap cycles plus SELECT, then the next winner
   task automatic ack_and_next(input string tag, input logic [5:0] exp_num);
      ext_ack = 1'b1;
      step(1);
      ext_ack = 1'b0;
      check_eq({tag, "_drop"}, ext_active, 1'b0);
      step(3);
      check_eq({tag, "_gap"}, ext_active, 1'b0);
      step(1);
      check_eq({tag, "_act"}, ext_active, 1'b1);
      check_eq({tag, "_num"}, ext_num, exp_num);
   endtask

   // ACK and let the gap run out with nothing left eligible
   task automatic ack_to_idle(input string tag);
      ext_ack = 1'b1;
      step(1);
      ext_ack = 1'b0;
      step(4);
      check_eq({tag, "_idle_act"}, ext_active, 1'b0);
      check_eq({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; req = '0; ict_valid = 1'b0; ict_entry = '0;
      ict_mask = 1'b0; ict_cvalid = 1'b0; ict_level = '0; ext_ack = 1'b0;
      step(3);
      rst = 1'b0;
      check_eq("rst_act", ext_active, 1'b0);
      check_eq("rst_num", ext_num, 6'd0);
      check_eq("rst_pend", pending, 64'd0);
      check_eq("rst_busy", busy, 1'b0);

      // Single unconfigured source
      req[5] = 1'b1;
      step(1);
      check_eq("s1_pend", pending, 64'd1 << 5);
      check_eq("s1_e0_busy", busy, 1'b0);
      step(1);
      check_eq("s1_e1_busy", busy, 1'b1);
      check_eq("s1_e1_act", ext_active, 1'b0);
      step(1);
      check_eq("s1_act", ext_active, 1'b1);
      check_eq("s1_num", ext_num, 6'd5);
      ext_ack = 1'b1;
      step(1);
      ext_ack = 1'b0;
      check_eq("s1_ack_act", ext_active, 1'b0);
      check_eq("s1_ack_pend", pending, 64'd0);
      check_eq("s1_hold_num", ext_num, 6'd5);
      step(6);
      check_eq("s1_held_act", ext_active, 1'b0);
      check_eq("s1_held_busy", busy, 1'b0);
      req[5] = 1'b0;
      step(1);
      req[5] = 1'b1;
      step(3);
      check_eq("s1_again_act", ext_active, 1'b1);
      check_eq("s1_again_num", ext_num, 6'd5);
      req[5] = 1'b0;
      ack_to_idle("s1");

      // Priority and tie-break
      ict_wr(6'd9, 1'b1, 1'b1, 2'd3);
      ict_wr(6'd2, 1'b1, 1'b1, 2'd1);
      ict_wr(6'd4, 1'b1, 1'b1, 2'd1);
      req[2] = 1'b1; req[4] = 1'b1; req[9] = 1'b1;
      step(1);
      check_eq("pri_pend", pending, 64'h214);
      step(2);
      check_eq("pri_first", ext_num, 6'd9);
      check_eq("pri_first_act", ext_active, 1'b1);
      ack_and_next("pri_second", 6'd2);
      ack_and_next("pri_third", 6'd4);
      ack_to_idle("pri");
      check_eq("pri_done_pend", pending, 64'd0);
      req = '0;

      // Masking, and ACK outside PRESENT ignored
      ict_wr(6'd7, 1'b0, 1'b1, 2'd0);
      req[7] = 1'b1;
      step(5);
      check_eq("msk_act", ext_active, 1'b0);
      check_eq("msk_pend", pending, 64'd1 << 7);
      check_eq("msk_busy", busy, 1'b0);
      ext_ack = 1'b1;
      step(1);
      ext_ack = 1'b0;
      check_eq("msk_stray_ack", pending, 64'd1 << 7);
      ict_wr(6'd7, 1'b1, 1'b1, 2'd0);
      step(2);
      check_eq("msk_open_act", ext_active, 1'b1);
      check_eq("msk_open_num", ext_num, 6'd7);
      req[7] = 1'b0;
      ack_to_idle("msk");

      // Stability of the presented request
      ict_wr(6'd10, 1'b1, 1'b1, 2'd3);
      req[3] = 1'b1;
      step(3);
      check_eq("stb_num0", ext_num, 6'd3);
      req[10] = 1'b1;
      step(3);
      check_eq("stb_num1", ext_num, 6'd3);
      check_eq("stb_pend", pending, (64'd1 << 3) | (64'd1 << 10));
      ict_wr(6'd3, 1'b0, 1'b1, 2'd0);
      step(1);
      check_eq("stb_rewr_act", ext_active, 1'b1);
      check_eq("stb_rewr_num", ext_num, 6'd3);
      ack_and_next("stb_next", 6'd10);
      req[3] = 1'b0; req[10] = 1'b0;
      ack_to_idle("stb");
      ict_wr(6'd3, 1'b0, 1'b0, 2'd0);

      // New edge on 3 in the same cycle as its ACK
      req[3] = 1'b1;
      step(3);
      check_eq("sc_num", ext_num, 6'd3);
      req[3] = 1'b0;
      step(1);
      req[3] = 1'b1;
      ext_ack = 1'b1;
      step(1);
      ext_ack = 1'b0;
      check_eq("sc_pend", pending, 64'd1 << 3);
      check_eq("sc_drop", ext_active, 1'b0);
      step(3);
      check_eq("sc_gap", ext_active, 1'b0);
      step(1);
      check_eq("sc_act", ext_active, 1'b1);
      check_eq("sc_num2", ext_num, 6'd3);

      // Reset while presenting, line 3 still high
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_eq("rr_act", ext_active, 1'b0);
      check_eq("rr_pend", pending, 64'd0);
      check_eq("rr_busy", busy, 1'b0);
      check_eq("rr_num", ext_num, 6'd0);
      step(5);
      check_eq("rr_nocap_pend", pending, 64'd0);
      check_eq("rr_nocap_busy", busy, 1'b0);
      req[3] = 1'b0;
      step(1);
      req[3] = 1'b1;
      step(1);
      check_eq("rr_recap_pend", pending, 64'd1 << 3);
      step(2);
      check_eq("rr_recap_num", ext_num, 6'd3);
      check_eq("rr_recap_act", ext_active, 1'b1);
      req[3] = 1'b0;
      ack_to_idle("rr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
